// File: rtl/interpolate_alu_vec.sv
// interpolate_alu_vec
//   Multi-channel linear interpolator for the ODE solver datapath:
//     Uk[c] = Un[c] + (Tk-Tn) * (Uz[c]-Un[c]) / (Tz-Tn)
//   All channels share one time base. One iterative restoring divider and
//   one multiplier are reused channel by channel. The slope keeps FRAC
//   fractional bits. Results saturate to WIDTH bits, with a per-channel
//   overflow flag.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             request, sampled only when not busy
//   Tk, Tn, Tz        target / left / right time (signed fixed, FRAC frac bits)
//   Un, Uz            left / right samples, channel c at [c*WIDTH +: WIDTH]
//   Uk                interpolated results, same packing
//   ovf               per-channel saturation flag
//   error             divide by zero (Tz == Tn)
//   busy, ready       operation in flight / result valid (level)
module interpolate_alu_vec #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 7,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WIDTH-1:0]            Tk,
    input  logic [WIDTH-1:0]            Tn,
    input  logic [WIDTH-1:0]            Tz,
    input  logic [CHANNELS*WIDTH-1:0]   Un,
    input  logic [CHANNELS*WIDTH-1:0]   Uz,
    output logic [CHANNELS*WIDTH-1:0]   Uk,
    output logic [CHANNELS-1:0]         ovf,
    output logic                        error,
    output logic                        busy,
    output logic                        ready
);
    localparam int NW  = WIDTH + FRAC + 1;   // scaled numerator width, also DIV cycle count
    localparam int DW  = WIDTH + 1;          // time difference width
    localparam int QW  = NW + 1;             // signed quotient width
    localparam int PW  = DW + QW;            // full product width
    localparam int CW  = $clog2(NW);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, MUL, WB, DONE} state_t;

    state_t                      state_q, state_d;
    logic [WIDTH-1:0]            tk_q, tk_d, tn_q, tn_d, tz_q, tz_d;
    logic [CHANNELS*WIDTH-1:0]   un_q, un_d, uz_q, uz_d;
    logic [CHANNELS*WIDTH-1:0]   uk_q, uk_d;
    logic [CHANNELS-1:0]         ovf_q, ovf_d;
    logic                        err_q, err_d;
    logic [DW-1:0]               den_q, den_d;
    logic                        dt_neg_q, dt_neg_d;
    logic [DW-1:0]               dk_q, dk_d;
    logic [DW-1:0]               rem_q, rem_d;
    logic [NW-1:0]               quo_q, quo_d;
    logic                        num_neg_q, num_neg_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [PW-1:0]        p_q, p_d;
    logic [CHW-1:0]              ch_q, ch_d;

    logic [DW-1:0]               dt_full, dk_full, diff;
    logic [CHW-1:0]              init_ch;
    logic [WIDTH-1:0]            un_sel, uz_sel, un_cur, sat;
    logic [NW-1:0]               num, num_mag;
    logic [DW:0]                 rem_shift, rem_sub;
    logic [QW-1:0]               q_mag, q_s;
    logic signed [PW-1:0]        dk_ext, q_ext, prod, s, max_v, min_v;
    logic                        sat_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tk_q      <= '0;
            tn_q      <= '0;
            tz_q      <= '0;
            un_q      <= '0;
            uz_q      <= '0;
            uk_q      <= '0;
            ovf_q     <= '0;
            err_q     <= 1'b0;
            den_q     <= '0;
            dt_neg_q  <= 1'b0;
            dk_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            num_neg_q <= 1'b0;
            cnt_q     <= '0;
            p_q       <= '0;
            ch_q      <= '0;
        end else begin
            state_q   <= state_d;
            tk_q      <= tk_d;
            tn_q      <= tn_d;
            tz_q      <= tz_d;
            un_q      <= un_d;
            uz_q      <= uz_d;
            uk_q      <= uk_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            den_q     <= den_d;
            dt_neg_q  <= dt_neg_d;
            dk_q      <= dk_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            num_neg_q <= num_neg_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            ch_q      <= ch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tk_d      = tk_q;
        tn_d      = tn_q;
        tz_d      = tz_q;
        un_d      = un_q;
        uz_d      = uz_q;
        uk_d      = uk_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        den_d     = den_q;
        dt_neg_d  = dt_neg_q;
        dk_d      = dk_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        num_neg_d = num_neg_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        ch_d      = ch_q;

        // Time differences carry one extra bit so they never wrap.
        dt_full = {tz_q[WIDTH-1], tz_q} - {tn_q[WIDTH-1], tn_q};
        dk_full = {tk_q[WIDTH-1], tk_q} - {tn_q[WIDTH-1], tn_q};

        // Divider setup for the channel about to enter DIV: channel 0 from
        // LOAD, the next channel from WB.
        init_ch = (state_q == WB) ? ch_q + 1'b1 : '0;
        un_sel  = un_q[init_ch*WIDTH +: WIDTH];
        uz_sel  = uz_q[init_ch*WIDTH +: WIDTH];
        diff    = {uz_sel[WIDTH-1], uz_sel} - {un_sel[WIDTH-1], un_sel};
        num     = {diff, {FRAC{1'b0}}};
        num_mag = num[NW-1] ? -num : num;

        // One restoring step: the dividend shifts out of quo_q MSB-first
        // while quotient bits shift in at the LSB.
        rem_shift = {rem_q, quo_q[NW-1]};
        rem_sub   = rem_shift - {1'b0, den_q};

        q_mag  = {1'b0, quo_q};
        q_s    = (num_neg_q ^ dt_neg_q) ? -q_mag : q_mag;
        dk_ext = {{(PW-DW){dk_q[DW-1]}}, dk_q};
        q_ext  = {{(PW-QW){q_s[QW-1]}}, q_s};
        prod   = dk_ext * q_ext;

        un_cur  = un_q[ch_q*WIDTH +: WIDTH];
        s       = {{(PW-WIDTH){un_cur[WIDTH-1]}}, un_cur} + p_q;
        max_v   = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
        min_v   = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
        sat_ovf = 1'b0;
        if (s > max_v) begin
            sat     = max_v[WIDTH-1:0];
            sat_ovf = 1'b1;
        end else if (s < min_v) begin
            sat     = min_v[WIDTH-1:0];
            sat_ovf = 1'b1;
        end else begin
            sat = s[WIDTH-1:0];
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    tk_d    = Tk;
                    tn_d    = Tn;
                    tz_d    = Tz;
                    un_d    = Un;
                    uz_d    = Uz;
                    err_d   = 1'b0;
                    ovf_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (dt_full == '0) begin
                    uk_d    = un_q;
                    ovf_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    den_d     = dt_full[DW-1] ? -dt_full : dt_full;
                    dt_neg_d  = dt_full[DW-1];
                    dk_d      = dk_full;
                    ch_d      = '0;
                    rem_d     = '0;
                    quo_d     = num_mag;
                    num_neg_d = num[NW-1];
                    cnt_d     = CW'(NW - 1);
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (!rem_sub[DW]) begin
                    rem_d = rem_sub[DW-1:0];
                    quo_d = {quo_q[NW-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[DW-1:0];
                    quo_d = {quo_q[NW-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = MUL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MUL: begin
                p_d     = prod >>> FRAC;
                state_d = WB;
            end
            WB: begin
                uk_d[ch_q*WIDTH +: WIDTH] = sat;
                ovf_d[ch_q]               = sat_ovf;
                if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    ch_d      = ch_q + 1'b1;
                    rem_d     = '0;
                    quo_d     = num_mag;
                    num_neg_d = num[NW-1];
                    cnt_d     = CW'(NW - 1);
                    state_d   = DIV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Uk    = uk_q;
    assign ovf   = ovf_q;
    assign error = err_q;
    assign busy  = (state_q != IDLE) && (state_q != DONE);
    assign ready = (state_q == DONE);

endmodule

// File: tb/tb_interpolate_alu_vec.sv
// Scoreboard bench for interpolate_alu_vec (default parameters).
module tb_interpolate_alu_vec;
    localparam int W = 16;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   Tk = '0, Tn = '0, Tz = '0;
    logic [C*W-1:0] Un = '0, Uz = '0;
    logic [C*W-1:0] Uk;
    logic [C-1:0]   ovf;
    logic           error, busy, ready;

    interpolate_alu_vec #(.WIDTH(16), .FRAC(7), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .Tk(Tk), .Tn(Tn), .Tz(Tz), .Un(Un), .Uz(Uz),
        .Uk(Uk), .ovf(ovf), .error(error), .busy(busy), .ready(ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [C*W-1:0] uk;
        logic [C-1:0]   ovf;
        logic           err;
        int             lat;
        int             t0;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [C*W-1:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic exp_t mk(input logic [C*W-1:0] uk, input logic [C-1:0] o,
                                input logic e, input int lat);
        exp_t r;
        r.uk = uk; r.ovf = o; r.err = e; r.lat = lat; r.t0 = 0;
        return r;
    endfunction

    // Monitor: every rising edge of ready is matched against the oldest expectation.
    initial begin : monitor
        logic rp;
        exp_t e;
        rp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rp = 1'b0;
            end else begin
                if (ready && !rp) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_ready: got ready=1 expected no result pending");
                    end else begin
                        e = sb.pop_front();
                        for (int c = 0; c < C; c++)
                            chk($sformatf("uk%0d", c), 64'(Uk[c*W +: W]), 64'(e.uk[c*W +: W]));
                        chk("ovf", 64'(ovf), 64'(e.ovf));
                        chk("error", 64'(error), 64'(e.err));
                        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                    end
                end
                rp = ready;
            end
        end
    end

    // Called at a negedge; the following posedge samples start.
    task automatic issue(input logic [W-1:0] tk, input logic [W-1:0] tn, input logic [W-1:0] tz,
                         input logic [C*W-1:0] un, input logic [C*W-1:0] uz, input exp_t e);
        Tk = tk; Tn = tn; Tz = tz; Un = un; Uz = uz;
        start = 1'b1;
        e.t0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        Tk = W'($urandom); Tn = W'($urandom); Tz = W'($urandom);
        Un = {$urandom, $urandom}; Uz = {$urandom, $urandom};
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got no ready within 300 cycles expected result");
            sb.delete();
        end
        chk("busy_when_done", 64'(busy), 64'd0);
    endtask

    localparam logic [C*W-1:0] T1_UN = {4{16'd0}};
    localparam logic [C*W-1:0] T1_UZ = {4{16'd512}};

    initial begin : stim
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_uk", 64'(Uk), 64'd0);
        chk("rst_flags", 64'({ovf, error, busy, ready}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: nominal, plus an ignored start 50 cycles in
        issue(16'd128, 16'd0, 16'd256, T1_UN, T1_UZ, mk({4{16'd256}}, 4'b0, 1'b0, 105));
        repeat (49) @(negedge clk);
        Tk = 16'd32767; Tn = 16'd0; Tz = 16'd1; Un = '0; Uz = {4{16'h7fff}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // 2: fraction retention
        issue(16'd128, 16'd0, 16'd384, {4{16'd0}}, {4{16'd128}},
              mk({4{16'd42}}, 4'b0, 1'b0, 105));
        wait_done();

        // 3: negative slope
        issue(16'd128, 16'd0, 16'd384, {4{16'd128}}, p4(-128, -128, -128, -128),
              mk({4{16'd43}}, 4'b0, 1'b0, 105));
        wait_done();

        // 3b: mixed channels, floor shift on negative product, wide difference
        issue(16'd100, 16'd0, 16'd384, p4(0, 0, 50, -32768), p4(-128, 128, 50, 32767),
              mk(p4(-33, 32, 50, -15702), 4'b0, 1'b0, 105));
        wait_done();

        // 3c: negative time step (Tz < Tn)
        issue(16'd256, 16'd384, 16'd0, p4(0, 10, 7, -1000), p4(128, -118, 7, -872),
              mk(p4(42, -32, 7, -958), 4'b0, 1'b0, 105));
        wait_done();

        // 4: divide by zero
        issue(16'd500, 16'd500, 16'd500, {4{16'd88}}, {4{16'd600}},
              mk({4{16'd88}}, 4'b0, 1'b1, 1));
        wait_done();

        // 5: saturation in both directions
        issue(16'd32767, 16'd0, 16'd1, p4(0, 0, 5, -5), p4(32767, -32768, 5, -5),
              mk(p4(32767, -32768, 5, -5), 4'b0011, 1'b0, 105));
        wait_done();

        // ovf from the previous run must clear on a start accepted in DONE
        issue(16'd128, 16'd0, 16'd256, T1_UN, T1_UZ, mk({4{16'd256}}, 4'b0, 1'b0, 105));
        wait_done();

        // 6: asynchronous reset during channel 2 division
        issue(16'd128, 16'd0, 16'd256, T1_UN, T1_UZ, mk({4{16'd256}}, 4'b0, 1'b0, 105));
        repeat (57) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_uk", 64'(Uk), 64'd0);
        chk("async_rst_flags", 64'({ovf, error, busy, ready}), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 64'({busy, ready}), 64'd0);
        issue(16'd128, 16'd0, 16'd256, T1_UN, T1_UZ, mk({4{16'd256}}, 4'b0, 1'b0, 105));
        wait_done();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
